a_sqrtb: RTL and testbench

- Sequential arithmetic unit computing y = a × floor(sqrt(b)) for unsigned 8-bit a and b. Result is 12-bit unsigned.
- Sits behind a simple valid/done handshake: the producer pulses in_ready and the consumer samples y_out once y_ready is high.
- Iterative implementation (digit-by-digit square root, then shift-add multiply) with fixed latency; no hardware multiplier on the datapath.

---
 rtl/a_sqrtb_if.sv | 13 +
 rtl/a_sqrtb.sv | 102 ++++++++++
 tb/tb_a_sqrtb.sv | 119 +++++++++++
 3 files changed

// File: rtl/a_sqrtb_if.sv
// Operand/result handshake bundle for the a*floor(sqrt(b)) unit.
interface a_sqrtb_if;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        in_ready;
    logic [11:0] y_out;
    logic        y_ready;

    modport master (output a_in, output b_in, output in_ready,
                    input  y_out, input  y_ready);
    modport slave  (input  a_in, input  b_in, input  in_ready,
                    output y_out, output y_ready);
endinterface

// File: rtl/a_sqrtb.sv
// Iterative y = a * floor(sqrt(b)): 4-cycle digit-by-digit root, then 4-cycle shift-add multiply.
module a_sqrtb (
    input  logic      clk,
    input  logic      rst,
    a_sqrtb_if.slave  bus
);
    localparam int unsigned AW = 8;
    localparam int unsigned RW = 4;
    localparam int unsigned YW = 12;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SQRT = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] b_q, b_d;
    logic [RW-1:0] root_q, root_d;
    logic [YW-1:0] acc_q, acc_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [YW-1:0] y_q, y_d;
    logic          rdy_q, rdy_d;

    logic [RW-1:0] trial;
    logic [AW-1:0] trial_sq;
    logic [YW-1:0] addend;

    assign trial    = root_q | (RW'(1) << cnt_q);
    assign trial_sq = AW'({4'd0, trial} * {4'd0, trial});
    assign addend   = YW'(a_q) << cnt_q;

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        root_d  = root_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        rdy_d   = rdy_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.in_ready) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    root_d  = '0;
                    acc_d   = '0;
                    cnt_d   = 2'd3;
                    rdy_d   = 1'b0;
                    state_d = S_SQRT;
                end
            end
            S_SQRT: begin
                if (trial_sq <= b_q) root_d = trial;
                if (cnt_q == 2'd0) begin
                    cnt_d   = 2'd0;
                    state_d = S_MUL;
                end else begin
                    cnt_d = 2'(cnt_q - 2'd1);
                end
            end
            S_MUL: begin
                if (root_q[cnt_q]) acc_d = YW'(acc_q + addend);
                if (cnt_q == 2'd3) begin
                    y_d     = acc_d;
                    rdy_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = 2'(cnt_q + 2'd1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            root_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            root_q  <= root_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.y_out   = y_q;
    assign bus.y_ready = rdy_q;
endmodule

// File: tb/tb_a_sqrtb.sv
// Directed bench for a_sqrtb with hand-computed results.
module tb_a_sqrtb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    a_sqrtb_if bus ();

    a_sqrtb u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
        end
    endtask

    // Pulse in_ready for the edge E0; returns just after E0 (on the following negedge).
    task automatic start(input logic [7:0] a, input logic [7:0] b);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_ready = 1'b1;
        @(negedge clk);
        bus.in_ready = 1'b0;
        bus.a_in     = 8'hA5;
        bus.b_in     = 8'h5A;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [11:0] exp);
        start(a, b);
        repeat (8) @(negedge clk);
        check({tag, "_rdy"}, 12'(bus.y_ready), 12'd1);
        check(tag, bus.y_out, exp);
    endtask

    logic [11:0] sweep_exp [11] = '{12'h000, 12'h07D, 12'h15E, 12'h258, 12'h3E8, 12'h55F,
                                    12'h708, 12'h8E3, 12'hAF0, 12'hD2F, 12'hEA6};

    initial begin
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.in_ready = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_y", bus.y_out, 12'h000);
        check("rst_rdy", 12'(bus.y_ready), 12'd0);
        repeat (5) @(negedge clk);
        check("idle_y", bus.y_out, 12'h000);
        check("idle_rdy", 12'(bus.y_ready), 12'd0);

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("sweep%0d", i), 8'(i * 25), 8'(i * 25 + 2), sweep_exp[i]);
        end

        run_op("max", 8'd255, 8'd255, 12'hEF1);
        run_op("b0", 8'd255, 8'd0, 12'h000);
        run_op("a0", 8'd0, 8'd255, 12'h000);
        run_op("sq16", 8'd1, 8'd16, 12'h004);
        run_op("sq225", 8'd3, 8'd225, 12'h02D);
        run_op("b15", 8'd1, 8'd15, 12'h003);

        // Latency: previous result 0x003 must hold through E7, new result appears at E8.
        start(8'd255, 8'd255);
        check("lat_e0_rdy", 12'(bus.y_ready), 12'd0);
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            check($sformatf("lat_e%0d_rdy", e), 12'(bus.y_ready), 12'd0);
            check($sformatf("lat_e%0d_hold", e), bus.y_out, 12'h003);
        end
        @(negedge clk);
        check("lat_e8_rdy", 12'(bus.y_ready), 12'd1);
        check("lat_e8_y", bus.y_out, 12'hEF1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d_rdy", c), 12'(bus.y_ready), 12'd1);
        end
        check("hold_y", bus.y_out, 12'hEF1);

        // Busy-ignore: second strobe sampled at E3 must not restart or re-latch.
        start(8'd10, 8'd100);
        @(negedge clk);
        @(negedge clk);
        bus.a_in     = 8'd200;
        bus.b_in     = 8'd200;
        bus.in_ready = 1'b1;
        @(negedge clk);
        bus.in_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_e7_rdy", 12'(bus.y_ready), 12'd0);
        @(negedge clk);
        check("busy_e8_rdy", 12'(bus.y_ready), 12'd1);
        check("busy_e8_y", bus.y_out, 12'h064);
        repeat (10) @(negedge clk);
        check("busy_late_rdy", 12'(bus.y_ready), 12'd1);
        check("busy_late_y", bus.y_out, 12'h064);

        // Reset at E4 aborts the operation.
        start(8'd100, 8'd100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_y", bus.y_out, 12'h000);
        check("abort_rdy", 12'(bus.y_ready), 12'd0);
        repeat (8) @(negedge clk);
        check("abort_late_y", bus.y_out, 12'h000);
        check("abort_late_rdy", 12'(bus.y_ready), 12'd0);
        run_op("after_abort", 8'd2, 8'd9, 12'h006);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
